chien_ctrl: RTL and testbench

Hardware initiator for the Chien-search accelerator's 32-bit command interface. Takes an error-locator polynomial σ(x) = 1 + σ1·x + σ2·x² + σ3·x³ + σ4·x⁴ over GF(2^PARAM_M) from the host. Loads the accelerator, then steps it through all evaluation points and streams out every root position. It replaces the software loop that drives the accelerator, and sits between the BCH decoder front-end (syndrome and Berlekamp–Massey) and the error-correction stage.

---
 rtl/chien_pkg.sv | 27 ++
 rtl/chien_root_collector.sv | 55 +++++
 rtl/chien_ctrl.sv | 153 +++++++++++++++
 tb/tb_chien_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/chien_pkg.sv
// Shared definitions for the Chien-search accelerator controller.
package chien_pkg;

    // Command bits in acc_in_2; exactly one is set while acc_enable is high.
    localparam int CMD_WR_LO = 31;
    localparam int CMD_WR_HI = 30;
    localparam int CMD_CALC  = 29;
    localparam int CMD_LOOP  = 28;

    // Bit offsets of the two data lanes inside each operand word.
    localparam int LANE_LO_OFS = 0;
    localparam int LANE_HI_OFS = 16;

    typedef enum logic [2:0] {
        S_IDLE, S_LD_LO, S_LD_HI, S_EVAL0, S_ISSUE, S_RELEASE, S_FIN
    } state_t;

    // Place two zero-extended field elements into their lanes of an operand word.
    function automatic logic [31:0] pack_lanes(input logic [15:0] lo, input logic [15:0] hi);
        logic [31:0] w;
        w = '0;
        w[LANE_LO_OFS +: 16] = lo;
        w[LANE_HI_OFS +: 16] = hi;
        return w;
    endfunction

endpackage

// File: rtl/chien_root_collector.sv
// Root decision, registered err_valid/err_pos, saturating root count and fail flag.
module chien_root_collector import chien_pkg::*; #(
    parameter int PARAM_M = 9,
    parameter int PW      = 9
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               chk_local,
    input  logic               chk_acc,
    input  logic [PARAM_M-1:0] chk_val,
    input  logic [PW-1:0]      chk_pos,
    input  logic               timeout,
    output logic               err_valid,
    output logic [PW-1:0]      err_pos,
    output logic [2:0]         err_count,
    output logic               fail
);

    localparam logic [PARAM_M-1:0] ONE = 1;

    // j=0 is evaluated locally (full sum incl. the constant term must be 0);
    // accelerator results omit the constant term, so a root reads back as 1.
    logic hit;
    assign hit = (chk_local && (chk_val == '0)) || (chk_acc && (chk_val == ONE));

    // Register the root pulse and maintain the count / fail status of the run.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_valid <= 1'b0;
            err_pos   <= '0;
            err_count <= '0;
            fail      <= 1'b0;
        end else begin
            err_valid <= hit;
            if (hit)
                err_pos <= chk_pos;
            if (clear) begin
                err_count <= '0;
                fail      <= 1'b0;
            end else begin
                if (hit) begin
                    if (err_count != 3'd7)
                        err_count <= err_count + 3'd1;
                    // A degree-4 locator cannot have a fifth root.
                    if (err_count >= 3'd4)
                        fail <= 1'b1;
                end
                if (timeout)
                    fail <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/chien_ctrl.sv
// Chien-search initiator: loads sigma/alpha lanes, steps the accelerator over all
// evaluation points and reports every root position.
module chien_ctrl import chien_pkg::*; #(
    parameter int  PARAM_M       = 9,
    parameter int  PARAM_N       = 511,
    parameter int  PARAM_TIMEOUT = 64,
    localparam int PW            = $clog2(PARAM_N)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [4*PARAM_M-1:0] sigma,
    input  logic [4*PARAM_M-1:0] alpha_pow,
    output logic                 busy,
    output logic                 err_valid,
    output logic [PW-1:0]        err_pos,
    output logic [2:0]           err_count,
    output logic                 done,
    output logic                 fail,
    output logic                 acc_enable,
    output logic [31:0]          acc_in_1,
    output logic [31:0]          acc_in_2,
    input  logic [31:0]          acc_out_1,
    input  logic                 acc_ready
);

    localparam int WW = $clog2(PARAM_TIMEOUT + 1);
    localparam logic [PARAM_M-1:0] ONE = 1;

    state_t               state_q, state_d;
    logic [4*PARAM_M-1:0] sig_q, alp_q;
    logic [PW-1:0]        j_q;
    logic [WW-1:0]        wd_q;
    logic                 seen_low_q;
    logic [31:0]          in1_q, in2_q, cmd;
    logic                 accept, chk_local, chk_acc, timeout;
    logic [PARAM_M-1:0]   eval0_r, chk_val;
    logic [PW-1:0]        chk_pos;
    logic                 unused_acc_hi;

    assign unused_acc_hi = ^acc_out_1[31:PARAM_M];

    assign accept  = (state_q == S_IDLE) && start;
    assign eval0_r = ONE ^ sig_q[0 +: PARAM_M] ^ sig_q[PARAM_M +: PARAM_M]
                   ^ sig_q[2*PARAM_M +: PARAM_M] ^ sig_q[3*PARAM_M +: PARAM_M];
    assign chk_val = chk_local ? eval0_r : acc_out_1[PARAM_M-1:0];
    assign chk_pos = chk_local ? '0 : j_q;

    // Data lanes are registered; command bits come straight from the state.
    assign acc_in_1 = in1_q;
    assign acc_in_2 = in2_q | cmd;

    // Next-state, command and strobe decode.
    always_comb begin
        state_d    = state_q;
        cmd        = '0;
        acc_enable = 1'b0;
        chk_local  = 1'b0;
        chk_acc    = 1'b0;
        timeout    = 1'b0;
        busy       = (state_q != S_IDLE) && (state_q != S_FIN);
        done       = (state_q == S_FIN);
        case (state_q)
            S_IDLE:  if (start) state_d = S_LD_LO;
            S_LD_LO: begin
                acc_enable     = 1'b1;
                cmd[CMD_WR_LO] = 1'b1;
                state_d        = S_LD_HI;
            end
            S_LD_HI: begin
                acc_enable     = 1'b1;
                cmd[CMD_WR_HI] = 1'b1;
                state_d        = S_EVAL0;
            end
            S_EVAL0: begin
                chk_local = 1'b1;
                state_d   = S_ISSUE;
            end
            S_ISSUE: begin
                acc_enable = 1'b1;
                if (j_q == PW'(1)) cmd[CMD_CALC] = 1'b1;
                else               cmd[CMD_LOOP] = 1'b1;
                // Only a ready that returns after a seen drop completes the step.
                if (seen_low_q && acc_ready) begin
                    state_d = S_RELEASE;
                end else if (wd_q == WW'(PARAM_TIMEOUT - 1)) begin
                    timeout = 1'b1;
                    state_d = S_FIN;
                end
            end
            S_RELEASE: begin
                chk_acc = 1'b1;
                state_d = (j_q == PW'(PARAM_N - 1)) ? S_FIN : S_ISSUE;
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State, operand latches, lane registers, step index and watchdog.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            sig_q      <= '0;
            alp_q      <= '0;
            in1_q      <= '0;
            in2_q      <= '0;
            j_q        <= '0;
            wd_q       <= '0;
            seen_low_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                sig_q <= sigma;
                alp_q <= alpha_pow;
                in1_q <= pack_lanes(16'(sigma[0 +: PARAM_M]), 16'(sigma[PARAM_M +: PARAM_M]));
                in2_q <= pack_lanes(16'(alpha_pow[0 +: PARAM_M]), 16'(alpha_pow[PARAM_M +: PARAM_M]));
            end
            if (state_q == S_LD_LO) begin
                in1_q <= pack_lanes(16'(sig_q[2*PARAM_M +: PARAM_M]), 16'(sig_q[3*PARAM_M +: PARAM_M]));
                in2_q <= pack_lanes(16'(alp_q[2*PARAM_M +: PARAM_M]), 16'(alp_q[3*PARAM_M +: PARAM_M]));
            end
            if (state_q == S_EVAL0)
                j_q <= PW'(1);
            else if (state_q == S_RELEASE)
                j_q <= j_q + PW'(1);
            if ((state_q == S_ISSUE) && (state_d == S_ISSUE)) begin
                wd_q <= wd_q + WW'(1);
                if (!acc_ready)
                    seen_low_q <= 1'b1;
            end else begin
                wd_q       <= '0;
                seen_low_q <= 1'b0;
            end
        end
    end

    chien_root_collector #(.PARAM_M(PARAM_M), .PW(PW)) u_collect (
        .clk       (clk),
        .rst       (rst),
        .clear     (accept),
        .chk_local (chk_local),
        .chk_acc   (chk_acc),
        .chk_val   (chk_val),
        .chk_pos   (chk_pos),
        .timeout   (timeout),
        .err_valid (err_valid),
        .err_pos   (err_pos),
        .err_count (err_count),
        .fail      (fail)
    );

endmodule

// File: tb/tb_chien_ctrl.sv
// Bench for chien_ctrl: behavioural GF(2^9) accelerator stub, polynomial-evaluation
// reference model, table of directed/random runs and hand-written corner sequences.
module tb_chien_ctrl;

    localparam int M  = 9;
    localparam int N  = 511;
    localparam int TO = 64;

    logic        clk = 1'b0;
    logic        rst, start;
    logic [35:0] sigma, alpha_pow;
    logic        busy, err_valid, done, fail, acc_enable, acc_ready;
    logic [8:0]  err_pos;
    logic [2:0]  err_count;
    logic [31:0] acc_in_1, acc_in_2, acc_out_1;

    always #5 clk = ~clk;

    chien_ctrl #(.PARAM_M(M), .PARAM_N(N), .PARAM_TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .start(start), .sigma(sigma), .alpha_pow(alpha_pow),
        .busy(busy), .err_valid(err_valid), .err_pos(err_pos), .err_count(err_count),
        .done(done), .fail(fail), .acc_enable(acc_enable), .acc_in_1(acc_in_1),
        .acc_in_2(acc_in_2), .acc_out_1(acc_out_1), .acc_ready(acc_ready)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // GF(2^9) arithmetic, primitive polynomial x^9 + x^4 + 1.
    function automatic logic [8:0] gmul(input logic [8:0] a, input logic [8:0] b);
        logic [8:0] p, x;
        p = '0;
        x = a;
        for (int i = 0; i < 9; i++) begin
            if (b[i]) p = p ^ x;
            x = x[8] ? ((x << 1) ^ 9'h011) : (x << 1);
        end
        return p;
    endfunction

    function automatic logic [8:0] gpow(input logic [8:0] a, input int e);
        logic [8:0] p;
        p = 9'd1;
        for (int i = 0; i < e; i++) p = gmul(p, a);
        return p;
    endfunction

    // sigma(x) = prod (1 + alpha^-r x) over the given root positions r.
    function automatic logic [35:0] sig_from_roots(input int r0, input int r1, input int r2,
                                                   input int r3, input int k);
        logic [8:0] c[5];
        int         rs[4];
        logic [8:0] b;
        rs = '{r0, r1, r2, r3};
        c  = '{9'd1, 9'd0, 9'd0, 9'd0, 9'd0};
        for (int i = 0; i < k; i++) begin
            b = gpow(9'd2, (N - rs[i]) % N);
            for (int d = 4; d >= 1; d--) c[d] = c[d] ^ gmul(b, c[d-1]);
        end
        return {c[4], c[3], c[2], c[1]};
    endfunction

    function automatic logic [35:0] alpha_pack(input logic [8:0] beta);
        return {gpow(beta, 4), gpow(beta, 3), gpow(beta, 2), beta};
    endfunction

    // ---------------- accelerator stub ----------------
    int         lat = 2;
    bit         hang = 1'b0;
    bit         force_one = 1'b0;
    logic [8:0] s_st[4], a_st[4], t_st[4];
    logic [8:0] stub_res, stub_sum, stub_tn;
    logic       lock;
    int         cnt;

    always @(posedge clk) begin
        if (rst) begin
            lock      <= 1'b0;
            acc_ready <= 1'b1;
            acc_out_1 <= '0;
            cnt       <= 0;
        end else begin
            if (acc_enable && acc_in_2[31]) begin
                s_st[0] <= acc_in_1[8:0];  s_st[1] <= acc_in_1[24:16];
                a_st[0] <= acc_in_2[8:0];  a_st[1] <= acc_in_2[24:16];
            end
            if (acc_enable && acc_in_2[30]) begin
                s_st[2] <= acc_in_1[8:0];  s_st[3] <= acc_in_1[24:16];
                a_st[2] <= acc_in_2[8:0];  a_st[3] <= acc_in_2[24:16];
            end
            if (lock && !acc_enable) begin
                lock      <= 1'b0;
                acc_ready <= 1'b1;
            end else if (acc_enable && (acc_in_2[29] || acc_in_2[28]) && !lock) begin
                lock      <= 1'b1;
                acc_ready <= 1'b0;
                cnt       <= lat;
                stub_sum = '0;
                for (int i = 0; i < 4; i++) begin
                    stub_tn = gmul(acc_in_2[29] ? s_st[i] : t_st[i], a_st[i]);
                    t_st[i] <= stub_tn;
                    stub_sum = stub_sum ^ stub_tn;
                end
                stub_res <= stub_sum;
            end else if (lock && !acc_ready && !hang) begin
                if (cnt <= 1) begin
                    acc_ready <= 1'b1;
                    acc_out_1 <= force_one ? 32'd1 : {23'd0, stub_res};
                end else begin
                    cnt <= cnt - 1;
                end
            end
        end
    end

    // ---------------- checking helpers ----------------
    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    typedef struct {
        logic [35:0] sig;
        logic [35:0] alp;
        int          lat;
        bit          hang;
        bit          force_one;
        int          inject_at;
        int          exp_n;     // -1: reference model only
        int          exp_p0;
        int          exp_p1;
        int          exp_cnt;
        bit          exp_fail;
    } vec_t;

    int exp_q[$];
    int got_q[$];

    // Reference: evaluate sigma at beta^j by Horner's rule for every position.
    task automatic model(input vec_t v);
        logic [8:0] s1, s2, s3, s4, x, y, beta;
        s1 = v.sig[8:0]; s2 = v.sig[17:9]; s3 = v.sig[26:18]; s4 = v.sig[35:27];
        beta = v.alp[8:0];
        x = 9'd1;
        exp_q.delete();
        for (int j = 0; j < N; j++) begin
            y = 9'd1 ^ gmul(x, s1 ^ gmul(x, s2 ^ gmul(x, s3 ^ gmul(x, s4))));
            if (j == 0) begin
                if (y == 9'd0) exp_q.push_back(0);
            end else if (!v.hang && (v.force_one || y == 9'd0)) begin
                exp_q.push_back(j);
            end
            x = gmul(x, beta);
        end
    endtask

    task automatic run_case(input int id, input vec_t v);
        int  cyc, en29, gaps, budget, fi, nexp;
        bit  seen_done;
        model(v);
        got_q.delete();
        lat = v.lat; hang = v.hang; force_one = v.force_one;
        @(negedge clk);
        sigma = v.sig; alpha_pow = v.alp; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk($sformatf("v%0d_ldlo_busy", id), busy, 1);
        chk($sformatf("v%0d_ldlo_en", id), acc_enable, 1);
        chk($sformatf("v%0d_ldlo_in1", id), acc_in_1, {7'd0, v.sig[17:9], 7'd0, v.sig[8:0]});
        chk($sformatf("v%0d_ldlo_in2", id), acc_in_2, {4'b1000, 3'd0, v.alp[17:9], 7'd0, v.alp[8:0]});
        chk($sformatf("v%0d_fail_clr", id), fail, 0);
        @(negedge clk);
        chk($sformatf("v%0d_ldhi_in1", id), acc_in_1, {7'd0, v.sig[35:27], 7'd0, v.sig[26:18]});
        chk($sformatf("v%0d_ldhi_in2", id), acc_in_2, {4'b0100, 3'd0, v.alp[35:27], 7'd0, v.alp[26:18]});
        cyc = 0; en29 = 0; gaps = 0; seen_done = 1'b0;
        budget = N * (v.lat + 5) + 200;
        while (!seen_done && cyc < budget) begin
            @(negedge clk);
            cyc++;
            start = (cyc == v.inject_at);
            if (start) sigma = ~v.sig;
            if (err_valid) got_q.push_back(int'(err_pos));
            if (acc_enable && acc_in_2[29]) en29++;
            if (!busy && !done) gaps++;
            if (done) begin
                seen_done = 1'b1;
                chk($sformatf("v%0d_busy_at_done", id), busy, 0);
                chk($sformatf("v%0d_count", id), err_count, (exp_q.size() > 7) ? 7 : exp_q.size());
                chk($sformatf("v%0d_fail", id), fail, (v.hang || exp_q.size() > 4) ? 1 : 0);
            end
        end
        start = 1'b0;
        chk($sformatf("v%0d_done_seen", id), seen_done, 1);
        chk($sformatf("v%0d_busy_gaps", id), gaps, 0);
        chk($sformatf("v%0d_npulse", id), got_q.size(), exp_q.size());
        fi = -1;
        for (int k = 0; k < got_q.size() && k < exp_q.size(); k++)
            if (fi < 0 && got_q[k] != exp_q[k]) fi = k;
        n_cmp++;
        if (fi >= 0) begin
            n_bad++;
            $display("FAIL v%0d_positions: pulse %0d err_pos %0d expected %0d", id, fi, got_q[fi], exp_q[fi]);
        end
        if (v.hang) chk($sformatf("v%0d_timeout_cycles", id), en29, TO);
        if (v.exp_n >= 0) begin
            nexp = got_q.size();
            chk($sformatf("v%0d_tbl_n", id), nexp, v.exp_n);
            chk($sformatf("v%0d_tbl_cnt", id), err_count, v.exp_cnt);
            chk($sformatf("v%0d_tbl_fail", id), fail, v.exp_fail);
            if (v.exp_n >= 1) chk($sformatf("v%0d_tbl_p0", id), (nexp > 0) ? got_q[0] : -1, v.exp_p0);
            if (v.exp_n >= 2) chk($sformatf("v%0d_tbl_p1", id), (nexp > 1) ? got_q[1] : -1, v.exp_p1);
        end
        @(negedge clk);
        chk($sformatf("v%0d_idle_after", id), {busy, done, acc_enable}, 0);
    endtask

    // ---------------- test sequence ----------------
    localparam int NV = 10;
    vec_t vt[NV];
    int   rr[4];
    int   k, nis, cyc;
    bit   dup, prev_en, cur_en;
    logic [35:0] a_std;
    logic [8:0]  beta;

    initial begin
        rst = 1'b1; start = 1'b0; sigma = '0; alpha_pow = '0;
        a_std = alpha_pack(9'd2);

        //            sig                               alp    lat hang frc inj  n   p0 p1  cnt fail
        vt[0] = '{36'd0,                               a_std, 12, 0, 0, -1,   0,  0, 0,  0, 0};
        vt[1] = '{36'd1,                               a_std,  2, 0, 0, -1,   1,  0, 0,  1, 0};
        vt[2] = '{sig_from_roots(3, 100, 0, 0, 2),     a_std,  2, 0, 0, -1,   2,  3, 100, 2, 0};
        vt[3] = '{36'd0,                               a_std,  2, 1, 0, -1,   0,  0, 0,  0, 1};
        vt[4] = '{36'd0,                               a_std,  2, 0, 1, -1, 510,  1, 2,  7, 1};
        vt[5] = '{sig_from_roots(7, 200, 400, 509, 4), a_std,  3, 0, 0, 300,  4,  7, 200, 4, 0};
        vt[6] = '{sig_from_roots(0, 510, 0, 0, 2),     a_std,  1, 0, 0, -1,   2,  0, 510, 2, 0};
        for (int i = 7; i < NV; i++) begin
            k = $urandom_range(0, 4);
            for (int a = 0; a < 4; a++) begin
                do begin
                    rr[a] = $urandom_range(0, N - 1);
                    dup = 1'b0;
                    for (int b = 0; b < a; b++) if (rr[b] == rr[a]) dup = 1'b1;
                end while (dup);
            end
            vt[i] = '{sig_from_roots(rr[0], rr[1], rr[2], rr[3], k), a_std,
                      $urandom_range(1, 6), 0, 0, -1, -1, 0, 0, 0, 0};
            if ($urandom_range(0, 2) == 0) begin
                beta = gpow(9'd2, $urandom_range(1, N - 1));
                vt[i].sig = 36'({$urandom(), $urandom()});
                vt[i].alp = alpha_pack(beta);
            end
        end

        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err_valid", err_valid, 0);
        chk("rst_fail", fail, 0);
        chk("rst_acc_enable", acc_enable, 0);
        chk("rst_err_pos_cnt", {err_pos, err_count}, 0);
        chk("rst_acc_in", {acc_in_1, acc_in_2}, 0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < NV; i++) run_case(i, vt[i]);

        // Reset in the middle of the ISSUE phase of step 10.
        lat = 2; hang = 1'b0; force_one = 1'b0;
        @(negedge clk);
        sigma = vt[2].sig; alpha_pow = vt[2].alp; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        nis = 0; cyc = 0; prev_en = 1'b0;
        while (nis < 10 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            cur_en = acc_enable && (acc_in_2[29] || acc_in_2[28]);
            if (cur_en && !prev_en) nis++;
            prev_en = cur_en;
        end
        chk("mid_reached_step10", nis, 10);
        chk("mid_cnt_before_rst", err_count, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_acc_enable", acc_enable, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_cnt_fail", {err_count, fail, err_valid, done}, 0);
        chk("mid_rst_acc_in", {acc_in_1, acc_in_2}, 0);
        run_case(99, vt[2]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
